// File: rtl/atten_pkg.sv
`default_nettype none
// ============================================================================
// Module  : atten_pkg
// Purpose : Shared constants, the sign/magnitude record and the conversion
//           function used by the attenuator sign splitter.
// Contents: ATTEN_BITS  default magnitude width
//           MAG_MAX     largest representable magnitude (2^ATTEN_BITS-1)
//           sign_mag_t  {sat, select, mag} record
//           to_sign_mag signed word -> {sat, select, mag}
// Revision: 1.0  initial release
// ============================================================================
package atten_pkg;

    localparam int ATTEN_BITS = 7;
    localparam int MAG_MAX    = (1 << ATTEN_BITS) - 1;

    typedef struct packed {
        logic                  sat;     // word was clamped
        logic                  select;  // 1 = non-negative
        logic [ATTEN_BITS-1:0] mag;     // magnitude
    } sign_mag_t;

    // The most negative word has no positive counterpart in ATTEN_BITS bits,
    // so it is clamped to MAG_MAX and flagged.
    function automatic sign_mag_t to_sign_mag(input logic [ATTEN_BITS:0] word);
        sign_mag_t r;
        r = '0;
        if (!word[ATTEN_BITS]) begin
            r.select = 1'b1;
            r.mag    = word[ATTEN_BITS-1:0];
        end else if (word[ATTEN_BITS-1:0] == '0) begin
            r.sat = 1'b1;
            r.mag = ATTEN_BITS'(MAG_MAX);
        end else begin
            r.mag = ATTEN_BITS'(-word);
        end
        return r;
    endfunction

endpackage : atten_pkg
`default_nettype wire

// File: rtl/atten_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : atten_skid_buf
// Purpose : Generic two-entry valid/ready skid buffer. A main output register
//           plus one skid register; the upstream ready is registered and equals
//           "skid register empty", so it never depends on i_m_ready.
// Ports   : clk, rst            clock, synchronous active-high reset
//           i_s_valid/o_s_ready upstream handshake, i_s_data payload in
//           o_m_valid/i_m_ready downstream handshake, o_m_data payload out
// Revision: 1.0  initial release
// ============================================================================
module atten_skid_buf #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_s_ready;

    logic             w_main_valid;
    logic [WIDTH-1:0] w_main_data;
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_data;
    logic             w_accept;
    logic             w_main_free;

    assign w_accept    = i_s_valid & r_s_ready;
    // Main register can take a new word this cycle: empty, or emptying now.
    assign w_main_free = ~r_main_valid | i_m_ready;

    always_comb begin
        w_main_valid = r_main_valid;
        w_main_data  = r_main_data;
        w_skid_valid = r_skid_valid;
        w_skid_data  = r_skid_data;
        if (w_main_free) begin
            if (r_skid_valid) begin
                // Skid drains first to keep order; no accept is possible
                // while it is full because upstream ready is low.
                w_main_valid = 1'b1;
                w_main_data  = r_skid_data;
                w_skid_valid = 1'b0;
            end else if (w_accept) begin
                w_main_valid = 1'b1;
                w_main_data  = i_s_data;
            end else begin
                w_main_valid = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_valid = 1'b1;
            w_skid_data  = i_s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_s_ready    <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid;
            r_main_data  <= w_main_data;
            r_skid_valid <= w_skid_valid;
            r_skid_data  <= w_skid_data;
            r_s_ready    <= ~w_skid_valid;
        end
    end

    assign o_s_ready = r_s_ready;
    assign o_m_valid = r_main_valid;
    assign o_m_data  = r_main_data;

endmodule : atten_skid_buf
`default_nettype wire

// File: rtl/atten_sign_split.sv
`default_nettype none
// ============================================================================
// Module  : atten_sign_split
// Purpose : Splits a stream of signed (BITS+1)-bit words into a BITS-bit
//           magnitude and a select bit (1 = non-negative) so that
//           select ? mag : -mag reproduces the input; the most negative word
//           is clamped to 2^BITS-1 and flagged. Registered skid buffering on
//           both handshakes, plus a saturating count of clamped accepts.
// Ports   : clk, rst                   clock, synchronous active-high reset
//           in_valid/in_ready/in_data  input word handshake
//           out_valid/out_ready        output word handshake
//           out_select/out_mag/out_sat converted word fields
//           sat_count/sat_clear        clamp event counter and its clear
// Revision: 1.0  initial release
// ============================================================================
module atten_sign_split
    import atten_pkg::*;
#(
    parameter int BITS  = ATTEN_BITS,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_select,
    output logic [BITS-1:0]  out_mag,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_count,
    input  logic             sat_clear
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [BITS+1:0]  w_payload;   // {sat, select, mag}
    logic [BITS+1:0]  w_out_word;
    logic             w_accept;
    logic             w_acc_sat;
    logic [CNT_W-1:0] r_sat_count;

    generate
        if (BITS == ATTEN_BITS) begin : g_conv_pkg
            sign_mag_t w_sm;
            assign w_sm      = to_sign_mag(in_data);
            assign w_payload = w_sm;
        end else begin : g_conv_generic
            always_comb begin
                w_payload = {1'b0, 1'b1, in_data[BITS-1:0]};
                if (in_data[BITS]) begin
                    if (in_data[BITS-1:0] == '0) begin
                        w_payload = {1'b1, 1'b0, {BITS{1'b1}}};
                    end else begin
                        w_payload = {1'b0, 1'b0, BITS'(-in_data)};
                    end
                end
            end
        end
    endgenerate

    atten_skid_buf #(
        .WIDTH (BITS + 2)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_s_valid (in_valid),
        .o_s_ready (in_ready),
        .i_s_data  (w_payload),
        .o_m_valid (out_valid),
        .i_m_ready (out_ready),
        .o_m_data  (w_out_word)
    );

    assign out_sat    = w_out_word[BITS+1];
    assign out_select = w_out_word[BITS];
    assign out_mag    = w_out_word[BITS-1:0];

    assign w_accept  = in_valid & in_ready;
    assign w_acc_sat = w_accept & w_payload[BITS+1];

    // A clear coinciding with a clamped accept counts that accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (sat_clear) begin
            r_sat_count <= w_acc_sat ? CNT_W'(1) : '0;
        end else if (w_acc_sat && (r_sat_count != c_CNT_MAX)) begin
            r_sat_count <= r_sat_count + CNT_W'(1);
        end
    end

    assign sat_count = r_sat_count;

endmodule : atten_sign_split
`default_nettype wire

// File: tb/tb_atten_sign_split.sv
`default_nettype none
// ============================================================================
// Module  : tb_atten_sign_split
// Purpose : Self-checking bench for atten_sign_split (BITS=7, CNT_W=16).
//           Accepted words are pushed into a queue of expected results from a
//           plain-arithmetic reference; a monitor pops on every transfer.
// Revision: 1.0  initial release
// ============================================================================
module tb_atten_sign_split;

    localparam int BITS  = 7;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BITS:0]    in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_select;
    logic [BITS-1:0]  out_mag;
    logic             out_sat;
    logic [CNT_W-1:0] sat_count;
    logic             sat_clear = 1'b0;

    atten_sign_split #(.BITS(BITS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_select (out_select),
        .out_mag    (out_mag),
        .out_sat    (out_sat),
        .sat_count  (sat_count),
        .sat_clear  (sat_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         v;     // accepted input value
        logic [8:0] exp;   // expected {sat, select, mag}
    } item_t;

    item_t q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    exp_cnt = 0;
    bit    rand_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: sign and absolute value with plain integer arithmetic.
    function automatic logic [8:0] ref_conv(input int v);
        if (v >= 0)         return {1'b0, 1'b1, 7'(v)};
        else if (v == -128) return {1'b1, 1'b0, 7'd127};
        else                return {1'b0, 1'b0, 7'(-v)};
    endfunction

    // Accept tracker: records every accepted word and models sat_count.
    initial begin
        forever begin
            int v;
            bit acc;
            bit acc_sat;
            @(negedge clk);
            if (rst) begin
                exp_cnt = 0;
                q.delete();
            end else begin
                acc     = in_valid && in_ready;
                v       = int'($signed(in_data));
                acc_sat = acc && (v == -128);
                if (acc) q.push_back('{v, ref_conv(v)});
                if (sat_clear)                       exp_cnt = acc_sat ? 1 : 0;
                else if (acc_sat && exp_cnt < 65535) exp_cnt++;
            end
        end
    end

    // Monitor: pops on each transfer and checks hold-stability under stall.
    initial begin
        bit         hold = 0;
        logic [8:0] held = '0;
        forever begin
            item_t it;
            int    rec;
            int    want;
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'({out_sat, out_select, out_mag}), 32'(held));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got word 0x%0h, want no output", {out_sat, out_select, out_mag});
                    end else begin
                        it = q.pop_front();
                        chk("out_word", 32'({out_sat, out_select, out_mag}), 32'(it.exp));
                        rec  = out_select ? int'(out_mag) : -int'(out_mag);
                        want = (it.v == -128) ? -127 : it.v;
                        chk("reconstruct", rec, want);
                    end
                    hold = 0;
                end else if (out_valid) begin
                    hold = 1;
                    held = {out_sat, out_select, out_mag};
                end else begin
                    hold = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input logic clr);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = w;
        sat_clear = clr;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        sat_clear = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_select", 32'(out_select), 32'd0);
        chk("rst_mag", 32'(out_mag), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Positive word, one-cycle latency.
        out_ready = 1'b1;
        send(8'd37, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_select", 32'(out_select), 32'd1);
        chk("t1_mag", 32'(out_mag), 32'd37);
        chk("t1_sat", 32'(out_sat), 32'd0);

        // Negative word then zero.
        send(8'(-37), 1'b0);
        chk("t2n_select", 32'(out_select), 32'd0);
        chk("t2n_mag", 32'(out_mag), 32'd37);
        chk("t2n_sat", 32'(out_sat), 32'd0);
        send(8'd0, 1'b0);
        chk("t2z_select", 32'(out_select), 32'd1);
        chk("t2z_mag", 32'(out_mag), 32'd0);
        chk("t2z_sat", 32'(out_sat), 32'd0);
        drain();

        // Most negative word: clamp and count.
        for (int i = 0; i < 3; i++) begin
            send(8'h80, 1'b0);
            chk("t3_select", 32'(out_select), 32'd0);
            chk("t3_mag", 32'(out_mag), 32'd127);
            chk("t3_sat", 32'(out_sat), 32'd1);
        end
        drain();
        chk("t3_sat_count3", 32'(sat_count), 32'd3);
        send(8'h80, 1'b1);
        chk("t3_clear_plus_sat", 32'(sat_count), 32'd1);
        drain();
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        chk("t3_clear_alone", 32'(sat_count), 32'd0);

        // Backpressure: A in main, B in skid.
        out_ready = 1'b0;
        send(8'd20, 1'b0);
        send(8'(-55), 1'b0);
        chk("t4_in_ready_low", 32'(in_ready), 32'd0);
        chk("t4_a_valid", 32'(out_valid), 32'd1);
        chk("t4_a_mag", 32'(out_mag), 32'd20);
        repeat (3) tick();
        chk("t4_a_still", 32'({out_select, out_mag}), 32'({1'b1, 7'd20}));
        out_ready = 1'b1;
        tick();
        chk("t4_b_next", 32'({out_select, out_mag}), 32'({1'b0, 7'd55}));
        chk("t4_in_ready_back", 32'(in_ready), 32'd1);
        drain();

        // Full throughput with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i * 29 - 100);
            @(negedge clk);
            chk("tput_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Randomized stream with random backpressure.
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    logic [7:0] w;
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
                    if ($urandom_range(0, 7) == 0) w = 8'h80;
                    else                           w = 8'($urandom);
                    send(w, 1'b0);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("t5_sat_count", 32'(sat_count), 32'(exp_cnt));

        // Reset with both entries full.
        out_ready = 1'b0;
        send(8'd11, 1'b0);
        send(8'd22, 1'b0);
        chk("t6_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_sat_count", 32'(sat_count), 32'd0);
        out_ready = 1'b1;
        rst = 1'b0;
        tick();
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_emit", 32'(out_valid), 32'd0);
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_atten_sign_split
`default_nettype wire
